iram_apb_loader: RTL and testbench
==================================

IRAM_APB_LOADER -- requirements
Module: iram_apb_loader

Interface
REQ-001 Parameter DWIDTH, default 16, APB data width; legal values 8, 16 and 32.
REQ-002 CLK  input  1  clock; all state changes on the rising edge.
REQ-003 RSTN  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  one-cycle pulse; starts a load when idle.
REQ-005 BASEADDR  input  15  first instruction-RAM word address, sampled on START.
REQ-006 COUNT  input  16  number of 9-bit words to load, sampled on START.
REQ-007 S_VALID  input  1, S_DATA  input  9, S_READY  output  1  word source stream; a transfer occurs when S_VALID and S_READY are both high on a rising edge.
REQ-008 PSEL, PENABLE, PWRITE  output  1 each; PADDR  output  8; PWDATA  output  DWIDTH  APB initiator request signals.
REQ-009 PRDATA  input  DWIDTH; PREADY  input  1; PSLVERR  input  1  APB responder return signals.
REQ-010 BUSY  output  1  load in progress; DONE  output  1  one-cycle completion pulse; ERROR  output  1  sticky error flag, cleared on START.

Function
REQ-011 Target map: PADDR 0x80 = page register (write PWDATA[7:0] = word address bits [14:7]); PADDR 0x84 = ninth-bit register (write PWDATA[0]); PADDR 0x00-0x7F = data window (PADDR[6:0] = word address bits [6:0]).
REQ-012 FSM states SHALL be IDLE, PAGE, NINTH, WAITD, DATA, RDBK, FIN; each APB transfer is one setup cycle (PSEL=1, PENABLE=0) followed by access cycles (PENABLE=1) that repeat until PREADY=1.
REQ-013 IDLE: on START with COUNT!=0, latch ADDR=BASEADDR and REM=COUNT, set BUSY, clear ERROR, force a page write, and go to WAITD.
REQ-014 START with COUNT=0 SHALL produce a DONE pulse on the next cycle with no APB transfer; START while BUSY=1 SHALL be ignored.
REQ-015 WAITD: S_READY=1 only in this state; on a transfer, latch the word into WD and go to PAGE if a page write is pending, else NINTH if required, else DATA.
REQ-016 PAGE: write ADDR[14:7] to 0x80; a page write is pending for the first word of a load and whenever ADDR[6:0] wrapped to 0.
REQ-017 NINTH (DWIDTH=8 only): write WD[8] to 0x84 for the first word and whenever WD[8] differs from the last value written; for DWIDTH>8 the block SHALL never address 0x84.
REQ-018 DATA: write to PADDR={1'b0,ADDR[6:0]}; PWDATA = WD zero-extended for DWIDTH>8, WD[7:0] for DWIDTH=8.
REQ-019 After a completed data write: ADDR increments modulo 2^15 (0x7FFF wraps to 0x0000, which forces a page write); REM decrements; at REM=0 go to FIN, else go to WAITD.
REQ-020 PSLVERR=1 in any completing access cycle SHALL set ERROR and go to FIN with no further transfers.
REQ-021 FIN: pulse DONE for one cycle, clear BUSY, return to IDLE.
REQ-022 PSEL, PENABLE, PWRITE and PADDR SHALL hold steady throughout the wait states of a transfer; PWDATA SHALL be driven only while PWRITE=1.
REQ-023 Minimum throughput: 3 cycles per word (WAITD + DATA setup + DATA access) when no page or ninth-bit write is needed and PREADY=1.

Reset
REQ-024 RSTN low SHALL immediately force state IDLE and drive PSEL, PENABLE, PWRITE, PADDR, PWDATA, S_READY, BUSY, DONE and ERROR to 0; ADDR, REM and WD are cleared.
REQ-025 Reset asserted during an APB transfer SHALL abort the transfer with no retry after reset is released.

Configuration
REQ-026 Macro IRAM_LOADER_VERIFY_EN defined: after each DATA write, enter RDBK, perform an APB read of the same PADDR, and compare PRDATA[8:0] to WD (PRDATA[7:0] to WD[7:0] when DWIDTH=8); on a mismatch set ERROR and go to FIN. The ADDR and REM updates occur only after a passing read.
REQ-027 Macro undefined: the RDBK state and its comparator SHALL be absent, and PRDATA SHALL be ignored.

Verification
REQ-028 DWIDTH=16, BASEADDR=0x007E, COUNT=3, PREADY=1 -> writes in order: 0x80<=0x00, 0x7E, 0x7F, 0x80<=0x01, 0x00; DONE pulse; ERROR=0.
REQ-029 DWIDTH=8, words 0x1A5, 0x1B6, 0x0C7 -> 0x84<=1 once, two data writes, 0x84<=0, third data write; PWDATA carries 0xA5, 0xB6, 0xC7.
REQ-030 BASEADDR=0x7FFF, COUNT=2 -> data write at page 0xFF/offset 0x7F, then page write 0x00, then data write at offset 0x00.
REQ-031 PREADY held low for 4 access cycles and PSLVERR=1 on the completing cycle -> request signals stable throughout, ERROR=1, DONE pulse, no further PSEL.
REQ-032 VERIFY_EN build, PRDATA returns 0x055 for written 0x155 (DWIDTH=16) -> ERROR=1 and DONE after the read; non-verify build -> no read transfers issued.
REQ-033 RSTN asserted in a DATA access cycle -> PSEL=0 and BUSY=0 immediately; START=1 with COUNT=0 after release -> DONE on the next cycle with no APB transfer.

Source files
------------

// File: rtl/iram_apb_loader.sv
// iram_apb_loader: streams 9-bit instruction words into an instruction RAM
// that sits behind an APB register window (page register, ninth-bit register
// and a 128-word data window).
//
// Build option: define IRAM_LOADER_VERIFY_EN to read back every data word
// over APB and flag a mismatch. Without the macro no read transfers exist
// and PRDATA is ignored.
//
// Handshakes: the word stream transfers on a rising edge where S_VALID and
// S_READY are both high; S_READY is high only while waiting for a word. APB
// transfers are one setup cycle (PSEL=1, PENABLE=0) then access cycles
// (PENABLE=1) until PREADY=1; PSLVERR is only looked at in that completing
// access cycle. Request signals come straight from registered state, so they
// cannot change while a transfer is waiting.
module iram_apb_loader #(
    parameter int DWIDTH = 16
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic [14:0]       BASEADDR,
    input  logic [15:0]       COUNT,
    input  logic              S_VALID,
    input  logic [8:0]        S_DATA,
    output logic              S_READY,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [7:0]        PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PAGE  = 3'd1,
        NINTH = 3'd2,
        WAITD = 3'd3,
        DATA  = 3'd4,
`ifdef IRAM_LOADER_VERIFY_EN
        RDBK  = 3'd5,
`endif
        FIN   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        access_q, access_d;      // 0 = setup cycle, 1 = access cycle
    logic [14:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [8:0]  wd_q, wd_d;
    logic        err_q, err_d;
    logic        page_pend_q, page_pend_d;
    logic        ninth_known_q, ninth_known_d; // ninth register written in this load
    logic        last9_q, last9_d;            // value last written to the ninth register

    logic [DWIDTH-1:0] data_word;
    logic [DWIDTH-1:0] page_word;
    logic [DWIDTH-1:0] ninth_word;
    logic              unused_sink;

    // Width-dependent write data for the three register targets.
    if (DWIDTH == 8) begin : g_w8
        assign data_word  = wd_q[7:0];
        assign page_word  = addr_q[14:7];
        assign ninth_word = {7'd0, wd_q[8]};
    end else begin : g_wn
        assign data_word  = {{(DWIDTH-9){1'b0}}, wd_q};
        assign page_word  = {{(DWIDTH-8){1'b0}}, addr_q[14:7]};
        assign ninth_word = '0;
    end

`ifdef IRAM_LOADER_VERIFY_EN
    logic rd_match;
    if (DWIDTH == 8) begin : g_cmp8
        assign rd_match = (PRDATA[7:0] == wd_q[7:0]);
    end else begin : g_cmpn
        assign rd_match = (PRDATA[8:0] == wd_q);
    end
`endif

    // Only the low PRDATA bits matter (or none, without read-back).
    assign unused_sink = ^PRDATA;

    // The ninth register is only used by 8-bit data paths, and is rewritten
    // only when the bit changes (or on the first word of a load).
    function automatic logic ninth_needed(input logic b);
        return (DWIDTH == 8) && (!ninth_known_q || (b != last9_q));
    endfunction

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= IDLE;
            access_q      <= 1'b0;
            addr_q        <= '0;
            rem_q         <= '0;
            wd_q          <= '0;
            err_q         <= 1'b0;
            page_pend_q   <= 1'b0;
            ninth_known_q <= 1'b0;
            last9_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            access_q      <= access_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            wd_q          <= wd_d;
            err_q         <= err_d;
            page_pend_q   <= page_pend_d;
            ninth_known_q <= ninth_known_d;
            last9_q       <= last9_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d       = state_q;
        access_d      = access_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        wd_d          = wd_q;
        err_d         = err_q;
        page_pend_d   = page_pend_q;
        ninth_known_d = ninth_known_q;
        last9_d       = last9_q;
        PSEL          = 1'b0;
        PWRITE        = 1'b0;
        PADDR         = 8'h00;
        PWDATA        = '0;
        S_READY       = 1'b0;
        BUSY          = 1'b1;
        DONE          = 1'b0;

        case (state_q)
            IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    err_d = 1'b0;
                    if (COUNT != 16'd0) begin
                        addr_d        = BASEADDR;
                        rem_d         = COUNT;
                        page_pend_d   = 1'b1;
                        ninth_known_d = 1'b0;
                        access_d      = 1'b0;
                        state_d       = WAITD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            WAITD: begin
                S_READY = 1'b1;
                if (S_VALID) begin
                    wd_d     = S_DATA;
                    access_d = 1'b0;
                    if (page_pend_q)               state_d = PAGE;
                    else if (ninth_needed(S_DATA[8])) state_d = NINTH;
                    else                           state_d = DATA;
                end
            end
            PAGE: begin
                PSEL   = 1'b1;
                PWRITE = 1'b1;
                PADDR  = 8'h80;
                PWDATA = page_word;
                if (!access_q) begin
                    access_d = 1'b1;
                end else if (PREADY) begin
                    access_d = 1'b0;
                    if (PSLVERR) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        page_pend_d = 1'b0;
                        state_d     = ninth_needed(wd_q[8]) ? NINTH : DATA;
                    end
                end
            end
            NINTH: begin
                PSEL   = 1'b1;
                PWRITE = 1'b1;
                PADDR  = 8'h84;
                PWDATA = ninth_word;
                if (!access_q) begin
                    access_d = 1'b1;
                end else if (PREADY) begin
                    access_d = 1'b0;
                    if (PSLVERR) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        ninth_known_d = 1'b1;
                        last9_d       = wd_q[8];
                        state_d       = DATA;
                    end
                end
            end
            DATA: begin
                PSEL   = 1'b1;
                PWRITE = 1'b1;
                PADDR  = {1'b0, addr_q[6:0]};
                PWDATA = data_word;
                if (!access_q) begin
                    access_d = 1'b1;
                end else if (PREADY) begin
                    access_d = 1'b0;
                    if (PSLVERR) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
`ifdef IRAM_LOADER_VERIFY_EN
                        state_d = RDBK;
`else
                        addr_d = addr_q + 15'd1;
                        rem_d  = rem_q - 16'd1;
                        if (addr_q[6:0] == 7'h7F) page_pend_d = 1'b1;
                        state_d = (rem_q == 16'd1) ? FIN : WAITD;
`endif
                    end
                end
            end
`ifdef IRAM_LOADER_VERIFY_EN
            RDBK: begin
                PSEL  = 1'b1;
                PADDR = {1'b0, addr_q[6:0]};
                if (!access_q) begin
                    access_d = 1'b1;
                end else if (PREADY) begin
                    access_d = 1'b0;
                    if (PSLVERR || !rd_match) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        addr_d = addr_q + 15'd1;
                        rem_d  = rem_q - 16'd1;
                        if (addr_q[6:0] == 7'h7F) page_pend_d = 1'b1;
                        state_d = (rem_q == 16'd1) ? FIN : WAITD;
                    end
                end
            end
`endif
            FIN: begin
                BUSY    = 1'b0;
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                BUSY    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign PENABLE     = PSEL & access_q;
    assign ERROR       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iram_apb_loader.sv
// Bench for iram_apb_loader: a 16-bit and an 8-bit instance, one active at a
// time. A negedge agent plays word source and APB responder and records
// every completed transfer; a queue-based model derives the expected
// transfer list from the load description.
module tb_iram_apb_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [14:0] base_i = '0;
    logic [15:0] count_i = '0;
    logic        s_valid = 1'b0;
    logic [8:0]  s_data = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic [31:0] prdata_v = '0;

    logic [1:0]  s_ready, psel, penable, pwrite, busy, done, err;
    logic [7:0]  paddr0, paddr1;
    logic [15:0] pwdata16;
    logic [7:0]  pwdata8;
    logic [2:0]  dbg0, dbg1;

    iram_apb_loader #(.DWIDTH(16)) dut16 (
        .CLK(clk), .RSTN(rstn), .START(start[0]), .BASEADDR(base_i), .COUNT(count_i),
        .S_VALID(s_valid), .S_DATA(s_data), .S_READY(s_ready[0]),
        .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]), .PADDR(paddr0),
        .PWDATA(pwdata16), .PRDATA(prdata_v[15:0]), .PREADY(pready), .PSLVERR(pslverr),
        .BUSY(busy[0]), .DONE(done[0]), .ERROR(err[0]), .dbg_state_o(dbg0)
    );

    iram_apb_loader #(.DWIDTH(8)) dut8 (
        .CLK(clk), .RSTN(rstn), .START(start[1]), .BASEADDR(base_i), .COUNT(count_i),
        .S_VALID(s_valid), .S_DATA(s_data), .S_READY(s_ready[1]),
        .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]), .PADDR(paddr1),
        .PWDATA(pwdata8), .PRDATA(prdata_v[7:0]), .PREADY(pready), .PSLVERR(pslverr),
        .BUSY(busy[1]), .DONE(done[1]), .ERROR(err[1]), .dbg_state_o(dbg1)
    );

    // Clock.
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Selected-instance view.
    logic        cur_sel = 1'b0;
    logic        m_psel, m_penable, m_pwrite, m_s_ready, m_busy, m_done, m_err;
    logic [7:0]  m_paddr;
    logic [31:0] m_pwdata;
    assign m_psel    = psel[cur_sel];
    assign m_penable = penable[cur_sel];
    assign m_pwrite  = pwrite[cur_sel];
    assign m_s_ready = s_ready[cur_sel];
    assign m_busy    = busy[cur_sel];
    assign m_done    = done[cur_sel];
    assign m_err     = err[cur_sel];
    assign m_paddr   = cur_sel ? paddr1 : paddr0;
    assign m_pwdata  = cur_sel ? {24'd0, pwdata8} : {16'd0, pwdata16};

    // Scoreboard: record = {write, paddr, data}.
    logic [40:0] exp_q[$];
    logic [40:0] obs_q[$];
    logic [8:0]  words_q[$];
    logic [8:0]  src_q[$];
    logic [31:0] mem [128];

    int tests = 0;
    int fails = 0;
    int force_waits = 0;
    int err_at = -1;
    int bad_rd_at = -1;
    bit gaps = 1'b0;
    int xfer_idx = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int stall = 0;
    logic [14:0] base_v = '0;
    logic [40:0] snap = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Agent: word source, APB responder and transfer recorder.
    always @(negedge clk) begin
        if (!rstn) begin
            pready  = 1'b0;
            pslverr = 1'b0;
            s_valid = 1'b0;
        end else begin
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prdata_v = $urandom;
            if (m_psel && !m_penable) begin
                snap    = {m_pwrite, m_paddr, m_pwdata};
                stall   = (force_waits >= 0) ? force_waits : $urandom_range(0, 2);
                pready  = 1'($urandom_range(0, 1));
                pslverr = 1'b0;
            end else if (m_psel && m_penable) begin
                check("apb_hold", {23'd0, m_pwrite, m_paddr, m_pwdata}, {23'd0, snap});
                if (stall > 0) begin
                    stall--;
                    pready  = 1'b0;
                    pslverr = 1'($urandom_range(0, 1));
                end else begin
                    pready  = 1'b1;
                    pslverr = (xfer_idx == err_at);
                    if (m_pwrite && m_paddr < 8'h80) mem[m_paddr[6:0]] = m_pwdata;
                    if (!m_pwrite)
                        prdata_v = mem[m_paddr[6:0]] ^ ((xfer_idx == bad_rd_at) ? 32'h100 : 32'h0);
                    obs_q.push_back({m_pwrite, m_paddr, m_pwdata});
                    xfer_idx++;
                end
            end else begin
                pready  = 1'($urandom_range(0, 1));
                pslverr = 1'b0;
            end
            if (m_busy && !m_pwrite) check("pwdata_gated", {32'd0, m_pwdata}, 64'd0);
            s_valid = (src_q.size() != 0) && (!gaps || $urandom_range(0, 2) != 0);
            s_data  = s_valid ? src_q[0] : 9'($urandom);
            if (s_valid && m_s_ready) void'(src_q.pop_front());
        end
    end

    // Reference: expected APB transfer list for words_q loaded at base_v.
    task automatic build_model(input bit is8);
        int a;
        bit have9;
        bit last9;
        logic [8:0] w;
        a = int'(base_v);
        have9 = 1'b0;
        last9 = 1'b0;
        exp_q.delete();
        for (int i = 0; i < words_q.size(); i++) begin
            w = words_q[i];
            if (i == 0 || a % 128 == 0) exp_q.push_back({1'b1, 8'h80, 32'(a / 128)});
            if (is8 && (!have9 || w[8] != last9)) begin
                exp_q.push_back({1'b1, 8'h84, 31'd0, w[8]});
                have9 = 1'b1;
                last9 = w[8];
            end
            exp_q.push_back({1'b1, 8'(a % 128), is8 ? {24'd0, w[7:0]} : {23'd0, w}});
`ifdef IRAM_LOADER_VERIFY_EN
            exp_q.push_back({1'b0, 8'(a % 128), 32'd0});
`endif
            a = (a + 1) % 32768;
        end
    endtask

    task automatic kick(input bit sel, input logic [14:0] base, input int waits,
                        input int err_i, input int bad_i, input bit gaps_i, input bit restart);
        @(negedge clk);
        cur_sel     = sel;
        base_v      = base;
        force_waits = waits;
        err_at      = err_i;
        bad_rd_at   = bad_i;
        gaps        = gaps_i;
        xfer_idx    = 0;
        done_cnt    = 0;
        obs_q.delete();
        src_q       = words_q;
        base_i      = base;
        count_i     = 16'(words_q.size());
        start[sel]  = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        start = 2'b00;
        if (restart) begin
            repeat (6) @(negedge clk);
            check("busy_mid_load", {63'd0, m_busy}, 64'd1);
            base_i     = base ^ 15'h1234;
            count_i    = 16'd1;
            start[sel] = 1'b1;
            @(negedge clk);
            start = 2'b00;
        end
    endtask

    task automatic finish_load(input string tag);
        int full;
        int first_bad;
        bit want_err;
        build_model(cur_sel);
        full = exp_q.size();
        first_bad = -1;
        if (err_at >= 0 && err_at < full) first_bad = err_at;
`ifdef IRAM_LOADER_VERIFY_EN
        if (bad_rd_at >= 0 && bad_rd_at < full && (first_bad < 0 || bad_rd_at < first_bad))
            first_bad = bad_rd_at;
`endif
        want_err = (first_bad >= 0);
        if (want_err) while (exp_q.size() > first_bad + 1) void'(exp_q.pop_back());
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
        if (done_cnt == 0) check({tag, "_timeout"}, 64'd1, 64'd0);
        if (!gaps && force_waits == 0 && !want_err)
            check({tag, "_latency"}, 64'(done_cyc - start_cyc),
                  64'(words_q.size() + 2 * exp_q.size() + 1));
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy"}, {63'd0, m_busy}, 64'd0);
        check({tag, "_psel_idle"}, {63'd0, m_psel}, 64'd0);
        check({tag, "_error"}, {63'd0, m_err}, {63'd0, want_err});
        check({tag, "_n_xfers"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_xfer%0d", tag, i), {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back(9'($urandom));
    endtask

    initial begin
        int n;
        bit found;
        logic [14:0] b;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ctrl", {50'd0, psel, penable, pwrite, s_ready, busy, done, err}, 64'd0);
        check("rst_paddr", {48'd0, paddr0, paddr1}, 64'd0);
        check("rst_pwdata", {40'd0, pwdata16, pwdata8}, 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Two pages touched, full-speed.
        words_q = '{9'h012, 9'h1FF, 9'h0A0};
        kick(1'b0, 15'h007E, 0, -1, -1, 1'b0, 1'b0);
        finish_load("page_cross");

        // Ninth-bit register handling on the 8-bit instance.
        words_q = '{9'h1A5, 9'h1B6, 9'h0C7};
        kick(1'b1, 15'h0123, 0, -1, -1, 1'b0, 1'b0);
        finish_load("ninth_bit");

        // Address space wrap.
        words_q = '{9'h101, 9'h002};
        kick(1'b0, 15'h7FFF, 0, -1, -1, 1'b0, 1'b0);
        finish_load("addr_wrap");

        // Wait states plus slave error on the first data write.
        rand_words(4);
        kick(1'b0, 15'h0200, 4, 1, -1, 1'b0, 1'b0);
        finish_load("slverr");

        // Read-back mismatch (only a read-back build issues reads).
        words_q = '{9'h155};
        kick(1'b0, 15'h0010, 0, -1, 2, 1'b0, 1'b0);
        finish_load("readback");

        // Randomised loads on both widths.
        for (int t = 0; t < 8; t++) begin
            n = (t == 4) ? $urandom_range(8, 20) : $urandom_range(1, 24);
            rand_words(n);
            b = (t % 2 == 0) ? 15'($urandom_range(0, 32767))
                             : {8'($urandom), 7'($urandom_range(110, 127))};
            kick(1'(t % 2), b, (t % 3 == 0) ? 0 : -1,
                 (t == 5) ? $urandom_range(0, 5) : -1, -1, t % 3 != 0, t == 4);
            finish_load($sformatf("rand%0d", t));
        end

        // Reset in the middle of a data access.
        rand_words(8);
        kick(1'b0, 15'h0300, 3, -1, -1, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (m_psel && m_penable && m_pwrite && m_paddr < 8'h80) found = 1'b1;
        end
        check("reach_data_access", {63'd0, found}, 64'd1);
        rstn = 1'b0;
        #1;
        check("rst_abort_psel", {62'd0, psel}, 64'd0);
        check("rst_abort_busy", {62'd0, busy}, 64'd0);
        check("rst_abort_penable", {62'd0, penable}, 64'd0);
        src_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        obs_q.delete();
        repeat (6) @(negedge clk);
        check("no_retry_xfers", 64'(obs_q.size()), 64'd0);
        check("no_retry_psel", {62'd0, psel}, 64'd0);

        // Empty load: DONE next cycle, no transfers.
        words_q.delete();
        kick(1'b0, 15'h0040, 0, -1, -1, 1'b0, 1'b0);
        finish_load("count_zero");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
